// File: rtl/fighter_pkg.sv
// Fighter package: state codes shared with the pixel renderer, datapath widths
// and a decode helper for the attack-active states.
package fighter_pkg;

    localparam int STATE_W = 4;
    localparam int COORD_W = 10;
    localparam int CNT_W   = 8;

    localparam logic [STATE_W-1:0] ST_IDLE          = 4'd0;
    localparam logic [STATE_W-1:0] ST_LEFT          = 4'd1;
    localparam logic [STATE_W-1:0] ST_RIGHT         = 4'd2;
    localparam logic [STATE_W-1:0] ST_ATK1_STARTUP  = 4'd3;
    localparam logic [STATE_W-1:0] ST_ATK1_ACTIVE   = 4'd4;
    localparam logic [STATE_W-1:0] ST_ATK1_RECOVERY = 4'd5;
    localparam logic [STATE_W-1:0] ST_ATK2_STARTUP  = 4'd6;
    localparam logic [STATE_W-1:0] ST_ATK2_ACTIVE   = 4'd7;
    localparam logic [STATE_W-1:0] ST_ATK2_RECOVERY = 4'd8;
    localparam logic [STATE_W-1:0] ST_HITSTUN       = 4'd9;

    function automatic logic is_hitbox_state(input logic [STATE_W-1:0] s);
        return (s == ST_ATK1_ACTIVE) || (s == ST_ATK2_ACTIVE);
    endfunction

endpackage

// File: rtl/fighter_position_clamp.sv
// Combinational next-x for one walking step.
// Ports:
//   i_x          current sprite x
//   i_move_right 1 = step toward +x, 0 = step toward -x
//   i_speed      step size in pixels
//   i_x_min/max  screen clamps
//   i_opp_x      opponent x
//   i_min_gap    minimum spacing to the opponent
//   i_gap_en     apply the opponent spacing limit (forward steps only)
//   o_x          clamped next x; holds i_x if the limit is already violated
module fighter_position_clamp
    import fighter_pkg::*;
(
    input  logic [COORD_W-1:0] i_x,
    input  logic               i_move_right,
    input  logic [COORD_W-1:0] i_speed,
    input  logic [COORD_W-1:0] i_x_min,
    input  logic [COORD_W-1:0] i_x_max,
    input  logic [COORD_W-1:0] i_opp_x,
    input  logic [COORD_W-1:0] i_min_gap,
    input  logic               i_gap_en,
    output logic [COORD_W-1:0] o_x
);

    // Two guard bits: opp_x + gap can exceed 1023 and x - speed can go negative.
    logic signed [COORD_W+1:0] w_x, w_spd, w_min, w_max, w_opp, w_gap;
    logic signed [COORD_W+1:0] w_cand, w_lim, w_new;

    assign w_x   = {2'b00, i_x};
    assign w_spd = {2'b00, i_speed};
    assign w_min = {2'b00, i_x_min};
    assign w_max = {2'b00, i_x_max};
    assign w_opp = {2'b00, i_opp_x};
    assign w_gap = {2'b00, i_min_gap};

    always_comb begin
        w_cand = w_x;
        w_lim  = w_x;
        w_new  = w_x;
        if (i_move_right) begin
            w_cand = w_x + w_spd;
            w_lim  = w_max;
            if (i_gap_en && ((w_opp - w_gap) < w_lim))
                w_lim = w_opp - w_gap;
            w_new = (w_cand < w_lim) ? w_cand : w_lim;
            // never let a right step move the sprite left
            if (w_new < w_x)
                w_new = w_x;
        end else begin
            w_cand = w_x - w_spd;
            w_lim  = w_min;
            if (i_gap_en && ((w_opp + w_gap) > w_lim))
                w_lim = w_opp + w_gap;
            w_new = (w_cand > w_lim) ? w_cand : w_lim;
            if (w_new > w_x)
                w_new = w_x;
        end
    end

    // Result lies between the screen clamps or equals i_x; guard bits only
    // matter for clamps configured outside the coordinate range.
    assign o_x = (w_new[COORD_W+1:COORD_W] != 2'b00) ? i_x : w_new[COORD_W-1:0];

endmodule

// File: rtl/fighter_state_machine.sv
// Per-player fighter controller: button levels -> state code and sprite x.
// Ports:
//   clk_game       one tick per game frame
//   reset          asynchronous, active-low
//   left_button / right_button / attack_button   synchronised levels
//   hit_in         one-tick pulse, opponent hitbox overlapped us
//   opp_x          opponent sprite x
//   state          4-bit state code (see table)
//   char_x         sprite left x
//   hitbox_active  high in ATK1_ACTIVE / ATK2_ACTIVE
//
// state          | meaning
// IDLE           | standing, no direction or both held
// LEFT / RIGHT   | walking, char_x moves this tick
// ATKn_STARTUP   | attack wind-up, no hitbox
// ATKn_ACTIVE    | hitbox live
// ATKn_RECOVERY  | attack cool-down
// HITSTUN        | stunned after being hit; reloads on repeat hits
module fighter_state_machine
    import fighter_pkg::*;
#(
    parameter int FACING_RIGHT = 1,
    parameter int X_INIT       = 100,
    parameter int X_MIN        = 0,
    parameter int X_MAX        = 512,
    parameter int FWD_SPEED    = 3,
    parameter int BACK_SPEED   = 2,
    parameter int MIN_GAP      = 40,
    parameter int A1_STARTUP   = 5,
    parameter int A1_ACTIVE    = 3,
    parameter int A1_RECOVERY  = 8,
    parameter int A2_STARTUP   = 8,
    parameter int A2_ACTIVE    = 4,
    parameter int A2_RECOVERY  = 14,
    parameter int HITSTUN_LEN  = 12
) (
    input  logic               clk_game,
    input  logic               reset,
    input  logic               left_button,
    input  logic               right_button,
    input  logic               attack_button,
    input  logic               hit_in,
    input  logic [COORD_W-1:0] opp_x,
    output logic [STATE_W-1:0] state,
    output logic [COORD_W-1:0] char_x,
    output logic               hitbox_active
);

    localparam logic               P_FACE_R = (FACING_RIGHT != 0);
    localparam logic [COORD_W-1:0] P_X_INIT = COORD_W'(X_INIT);
    localparam logic [COORD_W-1:0] P_X_MIN  = COORD_W'(X_MIN);
    localparam logic [COORD_W-1:0] P_X_MAX  = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] P_FWD    = COORD_W'(FWD_SPEED);
    localparam logic [COORD_W-1:0] P_BACK   = COORD_W'(BACK_SPEED);
    localparam logic [COORD_W-1:0] P_GAP    = COORD_W'(MIN_GAP);

    // Counter load values are LEN-1 so each phase lasts exactly LEN ticks.
    localparam logic [CNT_W-1:0] L_A1_S = CNT_W'(A1_STARTUP - 1);
    localparam logic [CNT_W-1:0] L_A1_A = CNT_W'(A1_ACTIVE - 1);
    localparam logic [CNT_W-1:0] L_A1_R = CNT_W'(A1_RECOVERY - 1);
    localparam logic [CNT_W-1:0] L_A2_S = CNT_W'(A2_STARTUP - 1);
    localparam logic [CNT_W-1:0] L_A2_A = CNT_W'(A2_ACTIVE - 1);
    localparam logic [CNT_W-1:0] L_A2_R = CNT_W'(A2_RECOVERY - 1);
    localparam logic [CNT_W-1:0] L_HS   = CNT_W'(HITSTUN_LEN - 1);

    logic [STATE_W-1:0] r_state, w_state_nxt;
    logic [COORD_W-1:0] r_x, w_x_nxt, w_x_step;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_attack_prev, r_hitbox;

    logic w_attack_edge, w_go_left, w_go_right, w_fwd_held, w_step_fwd, w_cnt_zero;

    assign w_attack_edge = attack_button & ~r_attack_prev;
    assign w_go_left     = left_button & ~right_button;
    assign w_go_right    = right_button & ~left_button;
    assign w_fwd_held    = P_FACE_R ? right_button : left_button;
    assign w_step_fwd    = (w_go_right == P_FACE_R);
    assign w_cnt_zero    = (r_cnt == '0);

    fighter_position_clamp u_clamp (
        .i_x          (r_x),
        .i_move_right (w_go_right),
        .i_speed      (w_step_fwd ? P_FWD : P_BACK),
        .i_x_min      (P_X_MIN),
        .i_x_max      (P_X_MAX),
        .i_opp_x      (opp_x),
        .i_min_gap    (P_GAP),
        .i_gap_en     (w_step_fwd),
        .o_x          (w_x_step)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_cnt_nxt   = w_cnt_zero ? r_cnt : r_cnt - 1'b1;
        if (hit_in) begin
            w_state_nxt = ST_HITSTUN;
            w_cnt_nxt   = L_HS;
        end else begin
            case (r_state)
                ST_IDLE, ST_LEFT, ST_RIGHT: begin
                    w_cnt_nxt = r_cnt;
                    if (w_attack_edge) begin
                        w_state_nxt = w_fwd_held ? ST_ATK2_STARTUP : ST_ATK1_STARTUP;
                        w_cnt_nxt   = w_fwd_held ? L_A2_S : L_A1_S;
                    end else if (w_go_left) begin
                        w_state_nxt = ST_LEFT;
                        w_x_nxt     = w_x_step;
                    end else if (w_go_right) begin
                        w_state_nxt = ST_RIGHT;
                        w_x_nxt     = w_x_step;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_ATK1_STARTUP:  if (w_cnt_zero) begin w_state_nxt = ST_ATK1_ACTIVE;   w_cnt_nxt = L_A1_A; end
                ST_ATK1_ACTIVE:   if (w_cnt_zero) begin w_state_nxt = ST_ATK1_RECOVERY; w_cnt_nxt = L_A1_R; end
                ST_ATK1_RECOVERY: if (w_cnt_zero) w_state_nxt = ST_IDLE;
                ST_ATK2_STARTUP:  if (w_cnt_zero) begin w_state_nxt = ST_ATK2_ACTIVE;   w_cnt_nxt = L_A2_A; end
                ST_ATK2_ACTIVE:   if (w_cnt_zero) begin w_state_nxt = ST_ATK2_RECOVERY; w_cnt_nxt = L_A2_R; end
                ST_ATK2_RECOVERY: if (w_cnt_zero) w_state_nxt = ST_IDLE;
                ST_HITSTUN:       if (w_cnt_zero) w_state_nxt = ST_IDLE;
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_game or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_x           <= P_X_INIT;
            r_cnt         <= '0;
            r_attack_prev <= 1'b0;
            r_hitbox      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_x           <= w_x_nxt;
            r_cnt         <= w_cnt_nxt;
            r_attack_prev <= attack_button;
            r_hitbox      <= is_hitbox_state(w_state_nxt);
        end
    end

    assign state         = r_state;
    assign char_x        = r_x;
    assign hitbox_active = r_hitbox;

endmodule
